// File: rtl/decrypt_pkg.sv
// Shared constants and types for the decrypt payload tagger and its framer.
package decrypt_pkg;

    localparam logic [7:0] CTRL_DATA    = 8'h00;
    localparam logic [7:0] MOD_HDR_CTRL = 8'hFF;
    localparam int         KEY_W        = 80;
    localparam int         STAGE_KEY_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        MODHDR,
        HDR,
        PAYLOAD
    } state_t;

endpackage

// File: rtl/decrypt_payload_tagger_pkt_framer.sv
// Packet framing FSM: tracks module-header / header / payload position of each
// transferred word and produces per-word sop, eop and is_payload pulses.
module pkt_framer
    import decrypt_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                CNT_W    = 8,
    parameter logic [CTRL_W-1:0] HDR_CTRL = CTRL_W'(MOD_HDR_CTRL)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              xfer_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [CNT_W-1:0]  hdr_words_cfg_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              is_payload_o
);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  hdr_q;
    logic [CNT_W-1:0]  hdr_eff;
    logic [CNT_W-1:0]  cnt_inc;
    logic              is_mod;
    logic              is_data;
    logic              is_eop;
    logic              reach;

    // Classify the current word and decide whether it starts a packet or is payload.
    // In IDLE the header length comes straight from the config, since it is sampled on this word.
    always_comb begin
        is_mod       = (ctrl_i == HDR_CTRL);
        is_data      = (ctrl_i == CTRL_W'(CTRL_DATA));
        is_eop       = !is_mod && !is_data;
        hdr_eff      = (state_q == IDLE) ? hdr_words_cfg_i : hdr_q;
        reach        = (state_q == PAYLOAD) || (cnt_q >= hdr_eff);
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        sop_o        = xfer_i && (((state_q == IDLE) && !is_eop) ||
                                  (is_mod && ((state_q == HDR) || (state_q == PAYLOAD))));
        eop_o        = xfer_i && is_eop;
        is_payload_o = xfer_i && ((is_data && reach) ||
                                  (is_eop && (state_q != IDLE) && reach));
    end

    // Framing state, saturating data-word count and per-packet header length; advance only on transfers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
        end else if (xfer_i) begin
            if (sop_o) begin
                hdr_q <= hdr_words_cfg_i;
            end
            if (is_eop) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (is_mod) begin
                if (state_q != MODHDR) begin
                    state_q <= MODHDR;
                    cnt_q   <= '0;
                end
            end else begin
                state_q <= reach ? PAYLOAD : HDR;
                cnt_q   <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/decrypt_payload_tagger.sv
// Tags payload words of the 64-bit packet stream ahead of the decryption pipeline,
// snapshots the round key per packet and registers the stream one cycle.
// Optional statistics counters are built when DECRYPT_PAYLOAD_TAGGER_STATS_EN is defined.
module decrypt_payload_tagger #(
    parameter int               DATA_W       = 64,
    parameter int               CTRL_W       = 8,
    parameter int               KEY_W        = 80,
    parameter int               CNT_W        = 8,
    parameter logic [CTRL_W-1:0] MOD_HDR_CTRL = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_wr,
    output logic              in_rdy,
    input  logic [KEY_W-1:0]  key_cfg,
    input  logic              decrypt_en_cfg,
    input  logic [CNT_W-1:0]  hdr_words_cfg,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_wr,
    input  logic              out_rdy,
    output logic [KEY_W-1:0]  out_key,
    output logic              out_inside_payload
`ifdef DECRYPT_PAYLOAD_TAGGER_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_payload_words
`endif
);

    import decrypt_pkg::*;

    logic              xfer;
    logic              sop;
    logic              eop;
    logic              is_payload;
    logic              tag_d;
    logic              pkt_en_q;
    logic              out_wr_q;
    logic              tag_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [KEY_W-1:0]  key_q;

    assign in_rdy = out_rdy;
    assign xfer   = in_wr & out_rdy;

    pkt_framer #(
        .CTRL_W   (CTRL_W),
        .CNT_W    (CNT_W),
        .HDR_CTRL (MOD_HDR_CTRL)
    ) u_framer (
        .clk_i           (clk),
        .reset_i         (reset),
        .xfer_i          (xfer),
        .ctrl_i          (in_ctrl),
        .hdr_words_cfg_i (hdr_words_cfg),
        .sop_o           (sop),
        .eop_o           (eop),
        .is_payload_o    (is_payload)
    );

    // On the SOP word itself the enable snapshot is not yet registered, so use the live config.
    assign tag_d = is_payload & (sop ? decrypt_en_cfg : pkt_en_q);

    // Output stage: stream registers, tag, and per-packet key/enable snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_q <= 1'b0;
            tag_q    <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
            key_q    <= '0;
            pkt_en_q <= 1'b0;
        end else begin
            out_wr_q <= xfer;
            tag_q    <= tag_d;
            if (xfer) begin
                data_q <= in_data;
                ctrl_q <= in_ctrl;
            end
            if (sop) begin
                key_q    <= key_cfg;
                pkt_en_q <= decrypt_en_cfg;
            end
        end
    end

    assign out_wr             = out_wr_q;
    assign out_inside_payload = tag_q;
    assign out_data           = data_q;
    assign out_ctrl           = ctrl_q;
    assign out_key            = key_q;

`ifdef DECRYPT_PAYLOAD_TAGGER_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_payload_words_q;

    // Free-running packet and payload-word counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pkts_q          <= '0;
            stat_payload_words_q <= '0;
        end else begin
            if (eop) begin
                stat_pkts_q <= stat_pkts_q + 32'd1;
            end
            if (tag_d) begin
                stat_payload_words_q <= stat_payload_words_q + 32'd1;
            end
        end
    end

    assign stat_pkts          = stat_pkts_q;
    assign stat_payload_words = stat_payload_words_q;
`else
    logic unused_eop;
    assign unused_eop = eop;
`endif

endmodule
